// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store controller between the execute stage and a byte-addressed,
// little-endian data memory with a 32-bit port.
//
// The controller handles one request at a time:
//   - Loads are sign- or zero-extended.
//   - Word stores are written directly.
//   - Byte and halfword stores use read-modify-write, because the memory
//     always writes the four bytes addr..addr+3.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/SH (addr[0]) and LW/SW (addr[1:0]) complete
//               as errors with no memory access.
//   undefined : no alignment check; every legal access proceeds at any address.
//
// Ports
//   clk, rst           clock (rising edge); asynchronous active-high reset
//   req_valid/ready    request handshake (see below)
//   req_we             1 = store, 0 = load
//   req_funct3         RV32I size/sign code
//   req_addr           byte address; only the low ADDR_W bits are used
//   req_wdata          store data, right-aligned
//   rsp_valid          one-cycle completion pulse
//   rsp_rdata          extended load data, 0 for stores and errors,
//                      held until the next response
//   rsp_err            error flag, meaningful with rsp_valid
//   mem_read           level read strobe; the memory acts on its rising edge
//   mem_write          write enable, sampled by the memory on clk
//   mem_addr           memory byte address
//   mem_wdata          memory write data
//   mem_rdata          memory read data
//
// Handshake
//   A request transfers on a rising clk edge where req_valid && req_ready.
//   req_ready is high only in IDLE.
//   The requester holds req_valid and the request fields stable until that
//   transfer. req_valid while not ready is ignored.
//   The response has no back-pressure: rsp_valid is a single-cycle pulse.
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_RSP  = 3'd4
   } state_t;

   // State register, kept as a named signal so checkers can bind to it.
   state_t state, state_n;

   // Request fields latched on accept.
   logic        we_q, we_n;
   logic [2:0]  f3_q, f3_n;
   logic [31:0] wdata_q, wdata_n;

   // Next values of the registered outputs.
   logic              rsp_valid_n;
   logic              rsp_err_n;
   logic [31:0]       rsp_rdata_n;
   logic              mem_read_n;
   logic              mem_write_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [31:0]       mem_wdata_n;

   logic        req_legal;
   logic        req_misaligned;
   logic [31:0] load_ext;
   logic [31:0] store_merge;

   // Address bits above the memory range are deliberately ignored.
   logic unused_addr_hi;
   assign unused_addr_hi = &{1'b0, req_addr[31:ADDR_W]};

   assign req_ready = (state == S_IDLE);

   // Legal size codes: loads 000/001/010/100/101, stores 000/001/010.
   always_comb begin
      req_legal = 1'b0;
      if (req_we) begin
         req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                     (req_funct3 == 3'b010);
      end else begin
         req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                     (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                     (req_funct3 == 3'b101);
      end
   end

`ifdef MISALIGN_TRAP_EN
   // funct3[1:0] gives the access size for every legal code:
   // 01 = halfword, 10 = word.
   assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                           ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign req_misaligned = 1'b0;
`endif

   // Load extension of the word read at the latched address.
   // The addressed byte is always in mem_rdata[7:0].
   always_comb begin
      load_ext = 32'h0;
      case (f3_q)
         3'b000:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         3'b001:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         3'b010:  load_ext = mem_rdata;
         3'b100:  load_ext = {24'h0, mem_rdata[7:0]};
         3'b101:  load_ext = {16'h0, mem_rdata[15:0]};
         default: load_ext = 32'h0;
      endcase
   end

   // Read-modify-write merge.
   // Only SB (funct3 000) and SH (funct3 001) reach this path, so funct3[0]
   // selects between the byte and the halfword form.
   // Upper bytes of the word read back are rewritten unchanged.
   always_comb begin
      if (f3_q[0]) begin
         store_merge = {mem_rdata[31:16], wdata_q[15:0]};
      end else begin
         store_merge = {mem_rdata[31:8], wdata_q[7:0]};
      end
   end

   // Next-state and next registered-output logic.
   always_comb begin
      state_n     = state;
      we_n        = we_q;
      f3_n        = f3_q;
      wdata_n     = wdata_q;
      rsp_valid_n = 1'b0;
      rsp_err_n   = rsp_err;
      rsp_rdata_n = rsp_rdata;
      mem_read_n  = mem_read;
      mem_write_n = mem_write;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;

      case (state)
         S_IDLE: begin
            if (req_valid) begin
               we_n    = req_we;
               f3_n    = req_funct3;
               wdata_n = req_wdata;
               if (!req_legal || req_misaligned) begin
                  // Error completes without touching memory or mem_addr.
                  state_n     = S_RSP;
                  rsp_valid_n = 1'b1;
                  rsp_err_n   = 1'b1;
                  rsp_rdata_n = 32'h0;
               end else if (req_we && (req_funct3 == 3'b010)) begin
                  state_n     = S_WR;
                  mem_write_n = 1'b1;
                  mem_addr_n  = req_addr[ADDR_W-1:0];
                  mem_wdata_n = req_wdata;
               end else begin
                  // Loads, and the read half of SB/SH.
                  state_n    = S_RD;
                  mem_read_n = 1'b1;
                  mem_addr_n = req_addr[ADDR_W-1:0];
               end
            end
         end

         S_RD: begin
            state_n = S_CAP;
         end

         S_CAP: begin
            // mem_rdata is sampled on the edge leaving CAP.
            mem_read_n = 1'b0;
            if (we_q) begin
               state_n     = S_WR;
               mem_write_n = 1'b1;
               mem_wdata_n = store_merge;
            end else begin
               state_n     = S_RSP;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b0;
               rsp_rdata_n = load_ext;
            end
         end

         S_WR: begin
            // The memory commits the write on the edge leaving WR.
            mem_write_n = 1'b0;
            state_n     = S_RSP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b0;
            rsp_rdata_n = 32'h0;
         end

         S_RSP: begin
            // mem_read is already low here, so consecutive reads are always
            // separated by a falling edge.
            state_n = S_IDLE;
         end

         default: begin
            state_n    = S_IDLE;
            mem_read_n  = 1'b0;
            mem_write_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         we_q      <= 1'b0;
         f3_q      <= 3'b000;
         wdata_q   <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'h0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
      end else begin
         state     <= state_n;
         we_q      <= we_n;
         f3_q      <= f3_n;
         wdata_q   <= wdata_n;
         rsp_valid <= rsp_valid_n;
         rsp_err   <= rsp_err_n;
         rsp_rdata <= rsp_rdata_n;
         mem_read  <= mem_read_n;
         mem_write <= mem_write_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//
// Bench for lsu_mem_ctrl. It contains:
//   - a 4096 x 8 little-endian memory model;
//   - directed requests that push {err, rdata}, the expected latency, and the
//     accept cycle into a scoreboard;
//   - a monitor that pops and compares on every rsp_valid pulse.
//
// Expected data follow little-endian byte placement.
// Example: SB at 0x011 replaces bits [15:8] of the word at 0x010.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

   localparam int LAT_LD  = 3;
   localparam int LAT_SW  = 2;
   localparam int LAT_RMW = 4;
   localparam int LAT_ERR = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_read;
   logic        mem_write;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   lsu_mem_ctrl #(.ADDR_W(12)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // ---------------- memory model ----------------
   // Reads act only on a rising mem_read, so a controller that never drops
   // the strobe returns stale data.
   logic [7:0]  mem [0:4095];
   logic [31:0] mem_rdata_r = 32'h0;
   assign mem_rdata = mem_rdata_r;

   always @(posedge mem_read) begin
      #1 mem_rdata_r = {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2],
                        mem[mem_addr + 12'd1], mem[mem_addr]};
   end

   always @(posedge clk) begin
      if (mem_write) begin
         for (int i = 0; i < 4; i++) mem[mem_addr + 12'(i)] <= mem_wdata[8*i +: 8];
      end
   end

   // ---------------- activity counters ----------------
   int cyc = 0;
   int wr_cycles = 0;
   int rd_rises = 0;
   int rd_falls = 0;
   int both_hi = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_write) wr_cycles <= wr_cycles + 1;
   end
   always @(posedge mem_read) rd_rises++;
   always @(negedge mem_read) rd_falls++;
   always @(negedge clk) if (mem_read && mem_write) both_hi++;

   // ---------------- scoreboard ----------------
   logic [32:0] exp_q[$];
   int          lat_q[$];
   int          acc_q[$];
   string       nm_q[$];
   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: compares every response against the head of the queue.
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_rsp: got err=%0b rdata=%h with empty queue",
                     rsp_err, rsp_rdata);
         end else begin
            automatic logic [32:0] e  = exp_q.pop_front();
            automatic int          l  = lat_q.pop_front();
            automatic int          a  = acc_q.pop_front();
            automatic string       nm = nm_q.pop_front();
            chk({nm, "_data"}, {rsp_err, rsp_rdata}, e);
            chk({nm, "_lat"}, 33'(cyc - a), 33'(l));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [32:0] exp, input int lat);
      int t;
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      nm_q.push_back(nm); exp_q.push_back(exp); lat_q.push_back(lat);
      t = 0;
      while (!req_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         n_chk++;
         $display("FAIL %s_accept: req_ready stayed 0 for %0d cycles", nm, t);
      end
      acc_q.push_back(cyc);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL drain_timeout: %0d responses outstanding, 0 expected", exp_q.size());
         exp_q.delete(); lat_q.delete(); acc_q.delete(); nm_q.delete();
      end
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   int w0, r0, f0;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 33'(req_ready), 33'd1);
      chk("rst_rsp_valid", 33'(rsp_valid), 33'd0);
      chk("rst_rsp_err",   33'(rsp_err),   33'd0);
      chk("rst_rsp_rdata", 33'(rsp_rdata), 33'd0);
      chk("rst_mem_read",  33'(mem_read),  33'd0);
      chk("rst_mem_write", 33'(mem_write), 33'd0);
      chk("rst_mem_addr",  33'(mem_addr),  33'd0);
      chk("rst_mem_wdata", 33'(mem_wdata), 33'd0);
      rst = 1'b0;

      // Word store and load back.
      issue("sw_010", 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 33'h0, LAT_SW);
      issue("lw_010", 1'b0, 3'b010, 32'h010, 32'h0, {1'b0, 32'hDEADBEEF}, LAT_LD);
      wait_idle();

      // SB at 0x011: only byte 0x011 changes; exactly one write cycle.
      w0 = wr_cycles;
      issue("sb_011", 1'b1, 3'b000, 32'h011, 32'hFFFFFF55, 33'h0, LAT_RMW);
      wait_idle();
      chk("sb_write_pulses", 33'(wr_cycles - w0), 33'd1);
      issue("lw_010b", 1'b0, 3'b010, 32'h010, 32'h0, {1'b0, 32'hDEAD55EF}, LAT_LD);

      // Sub-word loads with sign and zero extension.
      issue("lb_013",  1'b0, 3'b000, 32'h013, 32'h0, {1'b0, 32'hFFFFFFDE}, LAT_LD);
      issue("lbu_013", 1'b0, 3'b100, 32'h013, 32'h0, {1'b0, 32'h000000DE}, LAT_LD);
      issue("lh_012",  1'b0, 3'b001, 32'h012, 32'h0, {1'b0, 32'hFFFFDEAD}, LAT_LD);
      issue("lhu_012", 1'b0, 3'b101, 32'h012, 32'h0, {1'b0, 32'h0000DEAD}, LAT_LD);

      // SH merge, then loads with positive sign bits.
      issue("sw_030", 1'b1, 3'b010, 32'h030, 32'h11223344, 33'h0, LAT_SW);
      issue("sh_030", 1'b1, 3'b001, 32'h030, 32'hABCD1234, 33'h0, LAT_RMW);
      issue("lw_030", 1'b0, 3'b010, 32'h030, 32'h0, {1'b0, 32'h11221234}, LAT_LD);
      issue("lh_030", 1'b0, 3'b001, 32'h030, 32'h0, {1'b0, 32'h00001234}, LAT_LD);
      issue("lb_030", 1'b0, 3'b000, 32'h030, 32'h0, {1'b0, 32'h00000034}, LAT_LD);
      wait_idle();

      // Illegal codes: error, latency 1, no strobes.
      w0 = wr_cycles; r0 = rd_rises;
      issue("ld_f3_011", 1'b0, 3'b011, 32'h010, 32'h0, {1'b1, 32'h0}, LAT_ERR);
      issue("st_f3_100", 1'b1, 3'b100, 32'h010, 32'h12345678, {1'b1, 32'h0}, LAT_ERR);
      issue("ld_f3_110", 1'b0, 3'b110, 32'h010, 32'h0, {1'b1, 32'h0}, LAT_ERR);
      wait_idle();
      chk("err_no_write", 33'(wr_cycles - w0), 33'd0);
      chk("err_no_read",  33'(rd_rises - r0),  33'd0);

      // Back-to-back loads: mem_read must fall between them.
      issue("sw_100", 1'b1, 3'b010, 32'h100, 32'h12345678, 33'h0, LAT_SW);
      wait_idle();
      f0 = rd_falls;
      issue("b2b_lw_010", 1'b0, 3'b010, 32'h010, 32'h0, {1'b0, 32'hDEAD55EF}, LAT_LD);
      issue("b2b_lw_100", 1'b0, 3'b010, 32'h100, 32'h0, {1'b0, 32'h12345678}, LAT_LD);
      wait_idle();
      chk("b2b_read_falls", 33'(rd_falls - f0), 33'd2);

      // Word load at a non-word-aligned address.
`ifdef MISALIGN_TRAP_EN
      r0 = rd_rises;
      issue("lw_012", 1'b0, 3'b010, 32'h012, 32'h0, {1'b1, 32'h0}, LAT_ERR);
      wait_idle();
      chk("misalign_no_read", 33'(rd_rises - r0), 33'd0);
`else
      issue("lw_012", 1'b0, 3'b010, 32'h012, 32'h0, {1'b0, 32'h0000DEAD}, LAT_LD);
      wait_idle();
`endif

      // Reset during WR of an SB: the write is dropped and no response is issued.
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h020; req_wdata = 32'h77;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      begin
         int t = 0;
         while (!mem_write && t < 20) begin
            @(negedge clk);
            t++;
         end
      end
      chk("rmw_reached_wr", 33'(mem_write), 33'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_mem_write", 33'(mem_write), 33'd0);
      chk("rst_mid_req_ready", 33'(req_ready), 33'd1);
      chk("rst_mid_rsp_valid", 33'(rsp_valid), 33'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      issue("lw_020", 1'b0, 3'b010, 32'h020, 32'h0, {1'b0, 32'h00000000}, LAT_LD);
      wait_idle();

      chk("never_both_strobes", 33'(both_hi), 33'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
